// File: rtl/tick_scheduler_if.sv
// -----------------------------------------------------------------------------
// tick_scheduler_if
//   Configuration write bus for tick_scheduler. One producer (game logic
//   arbiter / testbench) drives a single-cycle write strobe that selects a
//   channel and loads its period and enable.
//
//   Handshake: cfg_wr is a fire-and-forget strobe. There is no ready/ack;
//   every cycle in which cfg_wr=1 is sampled at posedge clk is one write.
//   A write to a channel index >= NUM_CH is dropped without side effects.
//
//   Signals
//     cfg_wr       config write strobe, 1 cycle per write
//     cfg_ch       channel index (CH_W bits)
//     cfg_period   period in base ticks (CNT_W bits), 0 = hold / never tick
//     cfg_en       channel enable written together with the period
//     cfg_oneshot  (only with TICK_SCHED_ONESHOT_EN) channel stops after one tick
//
//   Modports
//     master  drives the bus
//     slave   tick_scheduler side, inputs only
//
//   Build option: TICK_SCHED_ONESHOT_EN adds cfg_oneshot.
// -----------------------------------------------------------------------------
interface tick_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic             cfg_en;
`ifdef TICK_SCHED_ONESHOT_EN
  logic             cfg_oneshot;
`endif

  modport master (
    output cfg_wr,
    output cfg_ch,
    output cfg_period,
`ifdef TICK_SCHED_ONESHOT_EN
    output cfg_oneshot,
`endif
    output cfg_en
  );

  modport slave (
    input cfg_wr,
    input cfg_ch,
    input cfg_period,
`ifdef TICK_SCHED_ONESHOT_EN
    input cfg_oneshot,
`endif
    input cfg_en
  );
endinterface

// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
//   Shared time base for the game logic. A free-running prescaler produces a
//   registered base tick every PRESCALE clk cycles; NUM_CH channel dividers
//   count base ticks and each emits a registered 1-cycle tick pulse plus a
//   square wave that flips on every tick.
//
//   Parameters
//     NUM_CH    number of channels (>=1)
//     PRESCALE  clk cycles per base tick (>=1)
//     PRE_W     prescaler counter width, must hold PRESCALE-1
//     CNT_W     channel period / counter width
//
//   Ports
//     clk        system clock, everything on posedge
//     resetn     synchronous active-low reset
//     cfg        tick_scheduler_if.slave configuration write bus
//     base_tick  registered prescaler pulse
//     tick       registered per-channel 1-cycle pulse
//     toggle     per-channel square wave, flips on each tick
//     active     current enable state per channel
//
//   Build option: TICK_SCHED_ONESHOT_EN
//     defined   : cfg.cfg_oneshot is stored per channel; a one-shot channel
//                 clears its enable in the cycle its tick is issued.
//     undefined : all channels are periodic.
//
//   There is no FSM: all state is plain counters and flags.
// -----------------------------------------------------------------------------
module tick_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = 50_000,
  parameter int PRE_W    = 32,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              resetn,
  tick_scheduler_if.slave   cfg,
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] toggle,
  output logic [NUM_CH-1:0] active
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              base_tick_q, base_tick_d;

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] toggle_q, toggle_d;
`ifdef TICK_SCHED_ONESHOT_EN
  logic [NUM_CH-1:0] oneshot_q, oneshot_d;
`endif

  // One-hot write select. An out-of-range cfg_ch matches no channel, which
  // is what makes such a write a no-op.
  logic [NUM_CH-1:0] wr_sel;

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = cfg.cfg_wr && (cfg.cfg_ch == CH_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler: free-running, never touched by configuration writes.
  // base_tick is registered, so it is high in the cycle after the counter
  // sat at PRESCALE-1. With PRESCALE=1 the counter is always at its last
  // value and base_tick stays high.
  // ---------------------------------------------------------------------------
  always_comb begin
    pre_cnt_d   = pre_cnt_q + PRE_W'(1);
    base_tick_d = 1'b0;
    if (pre_cnt_q == PRE_LAST) begin
      pre_cnt_d   = '0;
      base_tick_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel dividers. Counting uses the registered base_tick, so a channel
  // advances in the cycle where base_tick is visible on the output.
  // A write wins over counting on the same channel: the base tick of that
  // cycle is simply not seen by the rewritten channel. Writes never touch
  // the toggle phase.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    en_d     = en_q;
    toggle_d = toggle_q;
    tick_d   = '0;
`ifdef TICK_SCHED_ONESHOT_EN
    oneshot_d = oneshot_q;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_sel[i]) begin
        period_d[i] = cfg.cfg_period;
        en_d[i]     = cfg.cfg_en;
        cnt_d[i]    = '0;
`ifdef TICK_SCHED_ONESHOT_EN
        oneshot_d[i] = cfg.cfg_oneshot;
`endif
      end else if (base_tick_q && en_q[i] && (period_q[i] != '0)) begin
        if (cnt_q[i] == period_q[i] - CNT_W'(1)) begin
          cnt_d[i]    = '0;
          tick_d[i]   = 1'b1;
          toggle_d[i] = ~toggle_q[i];
`ifdef TICK_SCHED_ONESHOT_EN
          // Enable drops together with the tick so active falls in the
          // same cycle the pulse is seen.
          if (oneshot_q[i]) begin
            en_d[i] = 1'b0;
          end
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pre_cnt_q   <= '0;
      base_tick_q <= 1'b0;
      en_q        <= '0;
      tick_q      <= '0;
      toggle_q    <= '0;
`ifdef TICK_SCHED_ONESHOT_EN
      oneshot_q   <= '0;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        period_q[i] <= '0;
      end
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      base_tick_q <= base_tick_d;
      en_q        <= en_d;
      tick_q      <= tick_d;
      toggle_q    <= toggle_d;
`ifdef TICK_SCHED_ONESHOT_EN
      oneshot_q   <= oneshot_d;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        period_q[i] <= period_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign base_tick = base_tick_q;
  assign tick      = tick_q;
  assign toggle    = toggle_q;
  assign active    = en_q;

endmodule
